hamming_secded_decoder: RTL and testbench
=========================================

Name: hamming_secded_decoder

Overview:
- Parametrised, pipelined single-error-correct / double-error-detect (SECDED) Hamming decoder with a valid/ready stream interface on both sides.
- Successor to the combinational Hamming(7,4) decoder. Adds generic data width, an overall parity bit, backpressure and a two-stage pipeline.
- Optional saturating error counters.
- Sits between the memory/link read path and its consumers.

Parameters:
- DATA_W, default 4: data bits per codeword. Must be at least 1.
- P_W, derived as a localparam: smallest integer with 2^P_W >= DATA_W+P_W+1. Equals 3 at the default.
- CW_W, derived as a localparam: DATA_W+P_W+1, the codeword width including overall parity. Equals 8 at the default.
- CNT_W, default 16: width of each error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  codeword present on in_code.
- in_ready  out  1  decoder accepts the codeword this cycle.
- in_code  in  CW_W  codeword. Bit 0 is overall parity; bit i (i>=1) is Hamming position i. Power-of-two positions are check bits; the remaining positions carry data LSB-first, in ascending position order.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  corrected data.
- out_syndrome  out  P_W  raw syndrome.
- out_err_single  out  1  single error detected and corrected (includes the parity-bit-0 error).
- out_err_double  out  1  uncorrectable double error; out_data is uncorrected.
- err_cnt_single  out  CNT_W  present only with HAMMING_ERR_CNT_EN.
- err_cnt_double  out  CNT_W  present only with HAMMING_ERR_CNT_EN.

Behaviour:
- Reset: while rst=1 at a clock edge, both stage valid flags, out_valid, out_data, out_syndrome, out_err_* and the counters go to 0. Data in flight is discarded. in_ready reads 1 in the first cycle after reset.
- Stage 1 (S1), on transfer (in_valid && in_ready):
  - Register the codeword.
  - Register syndrome = XOR of the indices of all set positions 1..CW_W-1.
  - Register overall parity = XOR of all CW_W bits.
- Stage 2 (S2), from the S1 registers:
  - Syndrome 0, parity 0: no error.
  - Syndrome 0, parity 1: err_single, bit 0 flipped, data unchanged.
  - Syndrome s, parity 1: err_single, flip position s, then extract data.
  - Syndrome s, parity 0: err_double, data extracted uncorrected.
  - Syndrome s greater than CW_W-1 (shortened code), parity 1: report err_double, no flip.
- err_single and err_double are never both 1.
- Latency: 2 cycles from an input transfer to out_valid when there is no backpressure. Throughput is 1 codeword per cycle.
- Handshake:
  - S2 loads when !out_valid || out_ready. S1 loads when !s1_valid || S2 loads.
  - in_ready = !s1_valid || (!out_valid || out_ready).
  - Bubbles collapse. No combinational path from in_valid to out_valid.
  - Outputs are held stable while out_valid && !out_ready.
- Simultaneous transfer in and out on a full pipeline: both happen in the same cycle, with no loss and no duplication.
- in_code is ignored when in_valid=0.

Optional Feature:
- HAMMING_ERR_CNT_EN defined:
  - Counters increment by 1 on each output transfer (out_valid && out_ready) carrying err_single or err_double, respectively.
  - Counters saturate at 2^CNT_W-1.
  - Counters clear only on rst.
- HAMMING_ERR_CNT_EN undefined: counter ports and logic are absent. Datapath timing is identical.

Decomposition:
- Package hamming_pkg holds:
  - function calc_p_w(data_w);
  - function is_pow2(pos);
  - function data_pos(idx), mapping data index to codeword position;
  - typedef enum logic [1:0] err_kind_t with values ERR_NONE, ERR_SINGLE, ERR_DOUBLE.
- Sub-module hamming_syndrome: combinational, computes syndrome and overall parity from a codeword. It is reused by the future encoder checker.

Test Plan:
- DATA_W=4, in_code=8'hAA, out_ready=1 -> two cycles later out_data=4'b1011, syndrome=0, no error flags.
- in_code=8'h8A (bit 5 flipped) -> out_data=4'b1011, syndrome=5, err_single=1.
- in_code=8'hAB (parity bit flipped) -> out_data=4'b1011, syndrome=0, err_single=1.
- in_code=8'hCA (bits 5 and 6 flipped) -> syndrome=3, err_double=1, err_single=0.
- Backpressure: stream 5 codewords with out_ready toggling 1,0,0,1 ->
  - in_ready drops once both stages are full;
  - all 5 results arrive in order with no loss, and outputs stay stable while stalled;
  - asserting rst mid-stream gives out_valid=0 in the next cycle.
- With HAMMING_ERR_CNT_EN, CNT_W=2:
  - 5 single-error codewords -> err_cnt_single=3 (saturated), err_cnt_double=0.
  - DATA_W=11 sweep of all 16 single-bit flips on one codeword -> every flip is corrected.

Source files
------------

// File: rtl/hamming_pkg.sv
// ============================================================================
// Module      : hamming_pkg
// Description : Shared types and elaboration-time helpers for the SECDED
//               Hamming decoder family (decoder, syndrome core, encoder
//               checker).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hamming_pkg;

    // Classification of a decoded codeword
    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_SINGLE = 2'd1,
        ERR_DOUBLE = 2'd2
    } err_kind_t;

    // Smallest number of Hamming check bits p with 2^p >= data_w + p + 1
    function automatic int calc_p_w(input int data_w);
        int p;
        p = 0;
        for (int k = 1; k < 31; k++) begin
            if ((p == 0) && ((1 << k) >= (data_w + k + 1))) begin
                p = k;
            end
        end
        return p;
    endfunction

    // True when pos is a power of two (a check-bit position)
    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Codeword position of data bit idx: the idx-th non-power-of-two
    // position counting upward from position 3
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 3; p < 1024; p++) begin
            if (!is_pow2(p)) begin
                if ((cnt == idx) && (pos == 0)) begin
                    pos = p;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage : hamming_pkg

`default_nettype wire

// File: rtl/hamming_syndrome.sv
// ============================================================================
// Module      : hamming_syndrome
// Description : Combinational syndrome and overall-parity generator for an
//               extended Hamming codeword (bit 0 = overall parity, bit i =
//               Hamming position i). Shared with the encoder checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_syndrome #(
    parameter int CW_W = 8,
    parameter int P_W  = 3
) (
    input  logic [CW_W-1:0] i_code,
    output logic [P_W-1:0]  o_syndrome,
    output logic            o_parity
);

    // Syndrome is the XOR of the indices of every set position 1..CW_W-1
    always_comb begin
        o_syndrome = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (i_code[i]) begin
                o_syndrome = o_syndrome ^ P_W'(i);
            end
        end
    end

    assign o_parity = ^i_code;

endmodule : hamming_syndrome

`default_nettype wire

// File: rtl/hamming_secded_decoder.sv
// ============================================================================
// Module      : hamming_secded_decoder
// Description : Two-stage pipelined SECDED Hamming decoder with valid/ready
//               streams on both sides. Stage 1 registers the codeword with
//               its syndrome and overall parity; stage 2 classifies, corrects
//               and extracts the data into the output registers.
//               Optional saturating error counters: define HAMMING_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 16,
    localparam int P_W    = calc_p_w(DATA_W),
    localparam int CW_W   = DATA_W + P_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [P_W-1:0]    out_syndrome,
    output logic              out_err_single,
    output logic              out_err_double
`ifdef HAMMING_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]  err_cnt_single,
    output logic [CNT_W-1:0]  err_cnt_double
`endif
);

    generate
        if ((DATA_W < 1) || (CNT_W < 1)) begin : g_param_check
            $error("hamming_secded_decoder: DATA_W and CNT_W must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake: a stage loads when it is empty or its consumer drains it
    // ------------------------------------------------------------------
    logic w_s2_load;
    logic w_s1_load;
    logic r_s1_valid;

    assign w_s2_load = !out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    // ------------------------------------------------------------------
    // Stage 1: syndrome / parity of the incoming codeword
    // ------------------------------------------------------------------
    logic [P_W-1:0]  w_in_syn;
    logic            w_in_par;
    logic [CW_W-1:0] r_s1_code;
    logic [P_W-1:0]  r_s1_syn;
    logic            r_s1_par;

    hamming_syndrome #(
        .CW_W (CW_W),
        .P_W  (P_W)
    ) u_syndrome (
        .i_code     (in_code),
        .o_syndrome (w_in_syn),
        .o_parity   (w_in_par)
    );

    // Capture the codeword and its check results on each input transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
            r_s1_par   <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_code <= in_code;
                r_s1_syn  <= w_in_syn;
                r_s1_par  <= w_in_par;
            end
        end
    end

    // Check bits only matter through the syndrome already computed above
    logic w_unused_check_bits;
    assign w_unused_check_bits = ^r_s1_code;

    // ------------------------------------------------------------------
    // Stage 2: classify, correct and extract
    // ------------------------------------------------------------------
    err_kind_t           w_kind;
    logic                w_flip;
    logic [DATA_W-1:0]   w_data;

    // Error classification; syndromes beyond the last position of a
    // shortened code cannot be a single error, so they are reported double
    always_comb begin
        w_kind = ERR_NONE;
        w_flip = 1'b0;
        if (r_s1_syn == '0) begin
            if (r_s1_par) begin
                w_kind = ERR_SINGLE;
            end
        end else if (!r_s1_par) begin
            w_kind = ERR_DOUBLE;
        end else if (int'(r_s1_syn) > (CW_W - 1)) begin
            w_kind = ERR_DOUBLE;
        end else begin
            w_kind = ERR_SINGLE;
            w_flip = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
            localparam int POS = data_pos(gi);
            assign w_data[gi] = r_s1_code[POS] ^
                                (w_flip && (r_s1_syn == P_W'(POS)));
        end
    endgenerate

    // Output registers: load when empty or drained, otherwise hold steady
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_syndrome   <= '0;
            out_err_single <= 1'b0;
            out_err_double <= 1'b0;
        end else if (w_s2_load) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_data       <= w_data;
                out_syndrome   <= r_s1_syn;
                out_err_single <= (w_kind == ERR_SINGLE);
                out_err_double <= (w_kind == ERR_DOUBLE);
            end
        end
    end

`ifdef HAMMING_ERR_CNT_EN
    // ------------------------------------------------------------------
    // Saturating error counters, stepped on output transfers
    // ------------------------------------------------------------------
    logic w_out_xfer;
    assign w_out_xfer = out_valid && out_ready;

    // Count delivered single/double errors, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_single <= '0;
            err_cnt_double <= '0;
        end else if (w_out_xfer) begin
            if (out_err_single && (err_cnt_single != {CNT_W{1'b1}})) begin
                err_cnt_single <= err_cnt_single + CNT_W'(1);
            end
            if (out_err_double && (err_cnt_double != {CNT_W{1'b1}})) begin
                err_cnt_double <= err_cnt_double + CNT_W'(1);
            end
        end
    end
`endif

endmodule : hamming_secded_decoder

`default_nettype wire

// File: tb/tb_hamming_secded_decoder.sv
// ============================================================================
// Module      : tb_hamming_secded_decoder
// Description : Scoreboard bench for hamming_secded_decoder. A DATA_W=4
//               instance takes directed, backpressure, reset and random
//               traffic; a DATA_W=11 instance takes a single-bit-flip sweep.
//               Expected results come from an arithmetic SECDED model.
//               Counter checks are active when HAMMING_ERR_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hamming_secded_decoder;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  syn;
        logic        sgl;
        logic        dbl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DATA_W = 4 instance
    logic        in_valid4, in_ready4, out_valid4, out_ready4, es4, ed4;
    logic [7:0]  in_code4;
    logic [3:0]  out_data4;
    logic [2:0]  syn4;
    // DATA_W = 11 instance
    logic        in_valid11, in_ready11, out_valid11, out_ready11, es11, ed11;
    logic [15:0] in_code11;
    logic [10:0] out_data11;
    logic [3:0]  syn11;
`ifdef HAMMING_ERR_CNT_EN
    logic [1:0]  cs4, cd4;
    logic [15:0] cs11, cd11;
    int          exp_cs4, exp_cd4, exp_cs11, exp_cd11;
`endif

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t q4[$];
    exp_t q11[$];
    int   rmode = 0;
    bit   saw_stall4 = 0;

    hamming_secded_decoder #(
        .DATA_W (4)
`ifdef HAMMING_ERR_CNT_EN
        , .CNT_W (2)
`endif
    ) u_dut4 (
        .clk (clk), .rst (rst),
        .in_valid (in_valid4), .in_ready (in_ready4), .in_code (in_code4),
        .out_valid (out_valid4), .out_ready (out_ready4), .out_data (out_data4),
        .out_syndrome (syn4), .out_err_single (es4), .out_err_double (ed4)
`ifdef HAMMING_ERR_CNT_EN
        , .err_cnt_single (cs4), .err_cnt_double (cd4)
`endif
    );

    hamming_secded_decoder #(
        .DATA_W (11)
    ) u_dut11 (
        .clk (clk), .rst (rst),
        .in_valid (in_valid11), .in_ready (in_ready11), .in_code (in_code11),
        .out_valid (out_valid11), .out_ready (out_ready11), .out_data (out_data11),
        .out_syndrome (syn11), .out_err_single (es11), .out_err_double (ed11)
`ifdef HAMMING_ERR_CNT_EN
        , .err_cnt_single (cs11), .err_cnt_double (cd11)
`endif
    );

    // ---------------- reference model ----------------
    function automatic int pw_of(input int dw);
        int p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input int s, input logic sg, input logic db);
        exp_t e;
        e.data = d; e.syn = 8'(s); e.sgl = sg; e.dbl = db;
        return e;
    endfunction

    function automatic logic [31:0] encode(input logic [31:0] d, input int dw);
        int p = pw_of(dw);
        int cw = dw + p + 1;
        int k = 0;
        logic [31:0] c = '0;
        for (int pos = 1; pos < cw; pos++) begin
            if ($countones(pos) != 1) begin
                c[pos] = d[k];
                k++;
            end
        end
        for (int j = 0; j < p; j++) begin
            logic b;
            b = 1'b0;
            for (int pos = 1; pos < cw; pos++)
                if (((pos >> j) & 1) == 1 && pos != (1 << j)) b = b ^ c[pos];
            c[1 << j] = b;
        end
        c[0] = ^c;
        return c;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] code, input int dw);
        int p = pw_of(dw);
        int cw = dw + p + 1;
        int s = 0;
        int k = 0;
        logic par;
        logic [31:0] c = code;
        exp_t r = '0;
        for (int pos = 1; pos < cw; pos++) if (c[pos]) s = s ^ pos;
        par = ^(c & ((32'd1 << cw) - 32'd1));
        r.syn = 8'(s);
        if (s == 0) r.sgl = par;
        else if (par && s < cw) begin r.sgl = 1'b1; c[s] = ~c[s]; end
        else r.dbl = 1'b1;
        for (int pos = 1; pos < cw; pos++) begin
            if ($countones(pos) != 1) begin
                r.data[k] = c[pos];
                k++;
            end
        end
        return r;
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic chk(input string name, input exp_t act, input exp_t want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got data=%0h syn=%0d s=%0b d=%0b, want data=%0h syn=%0d s=%0b d=%0b",
                     name, act.data, act.syn, act.sgl, act.dbl,
                     want.data, want.syn, want.sgl, want.dbl);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            q4.delete();
            q11.delete();
`ifdef HAMMING_ERR_CNT_EN
            exp_cs4 = 0; exp_cd4 = 0; exp_cs11 = 0; exp_cd11 = 0;
`endif
        end else begin
`ifdef HAMMING_ERR_CNT_EN
            chk_int("cnt_single4", int'(cs4), exp_cs4);
            chk_int("cnt_double4", int'(cd4), exp_cd4);
            chk_int("cnt_single11", int'(cs11), exp_cs11);
            chk_int("cnt_double11", int'(cd11), exp_cd11);
`endif
            if (!out_valid4 || out_ready4) chk_int("in_ready4_rule", int'(in_ready4), 1);
            if (!in_ready4) saw_stall4 = 1;
            if (out_valid4) begin
                if (q4.size() == 0) chk_int("out4_unexpected_valid", 1, 0);
                else begin
                    chk("out4", mk(32'(out_data4), int'(syn4), es4, ed4), q4[0]);
                    if (out_ready4) begin
`ifdef HAMMING_ERR_CNT_EN
                        if (q4[0].sgl && exp_cs4 < 3) exp_cs4++;
                        if (q4[0].dbl && exp_cd4 < 3) exp_cd4++;
`endif
                        void'(q4.pop_front());
                    end
                end
            end
            if (out_valid11) begin
                if (q11.size() == 0) chk_int("out11_unexpected_valid", 1, 0);
                else begin
                    chk("out11", mk(32'(out_data11), int'(syn11), es11, ed11), q11[0]);
                    if (out_ready11) begin
`ifdef HAMMING_ERR_CNT_EN
                        if (q11[0].sgl) exp_cs11++;
                        if (q11[0].dbl) exp_cd11++;
`endif
                        void'(q11.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- out_ready drivers ----------------
    initial begin
        int pat[4] = '{1, 0, 0, 1};
        int pidx = 0;
        out_ready4  = 1'b1;
        out_ready11 = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready11 = 1'($urandom_range(0, 1));
            case (rmode)
                0: out_ready4 = 1'b1;
                1: begin out_ready4 = 1'(pat[pidx]); pidx = (pidx + 1) % 4; end
                2: out_ready4 = 1'($urandom_range(0, 1));
                default: out_ready4 = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic send4(input logic [7:0] code, input exp_t e);
        bit done = 0;
        in_valid4 = 1'b1;
        in_code4  = code;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready4) begin q4.push_back(e); done = 1; end
            @(posedge clk); #1;
        end
        if (!done) begin chk_int("send4_timeout", 0, 1); in_valid4 = 1'b0; end
    endtask

    task automatic send11(input logic [15:0] code, input exp_t e);
        bit done = 0;
        in_valid11 = 1'b1;
        in_code11  = code;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready11) begin q11.push_back(e); done = 1; end
            @(posedge clk); #1;
        end
        if (!done) begin chk_int("send11_timeout", 0, 1); in_valid11 = 1'b0; end
    endtask

    task automatic rand4(input int max_err);
        logic [31:0] c;
        int nerr;
        int b0;
        int b1;
        c    = encode(32'($urandom_range(0, 15)), 4);
        nerr = $urandom_range(0, max_err);
        b0   = $urandom_range(0, 7);
        b1   = (b0 + $urandom_range(1, 7)) % 8;
        if (nerr >= 1) c[b0] = ~c[b0];
        if (nerr >= 2) c[b1] = ~c[b1];
        send4(c[7:0], ref_decode(c, 4));
    endtask

    task automatic drain();
        bit done = 0;
        in_valid4  = 1'b0;
        in_valid11 = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(posedge clk); #1;
            if (q4.size() == 0 && q11.size() == 0) done = 1;
        end
        if (!done) chk_int("drain_timeout", 0, 1);
    endtask

    initial begin
        logic [31:0] c11;
        rst = 1'b1;
        in_valid4 = 1'b0;  in_code4  = '0;
        in_valid11 = 1'b0; in_code11 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset4", mk(32'(out_data4), int'(syn4), es4, ed4), '0);
        chk_int("reset_out_valid4", int'(out_valid4), 0);
        chk_int("reset_in_ready4", int'(in_ready4), 1);
        chk_int("reset_out_valid11", int'(out_valid11), 0);
        @(posedge clk); #1;

        // directed vectors
        send4(8'hAA, mk(32'hB, 0, 1'b0, 1'b0));
        send4(8'h8A, mk(32'hB, 5, 1'b1, 1'b0));
        send4(8'hAB, mk(32'hB, 0, 1'b1, 1'b0));
        send4(8'hCA, mk(32'hD, 3, 1'b0, 1'b1));
        drain();

        // backpressure stream with out_ready 1,0,0,1
        rmode = 1;
        saw_stall4 = 0;
        for (int i = 0; i < 5; i++) rand4(2);
        drain();
        chk_int("stall_seen", int'(saw_stall4), 1);

        // fill both stages under full stall, then reset mid-stream
        rmode = 3;
        repeat (2) @(posedge clk);
        #1;
        rand4(2);
        rand4(2);
        in_valid4 = 1'b1;
        in_code4  = 8'hAA;
        @(negedge clk);
        chk_int("full_in_ready4", int'(in_ready4), 0);
        chk_int("full_out_valid4", int'(out_valid4), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_int("post_rst_out_valid4", int'(out_valid4), 0);
        chk_int("post_rst_in_ready4", int'(in_ready4), 1);
        rmode = 0;
        @(posedge clk); #1;

        // five single-error codewords
        for (int i = 0; i < 5; i++) begin
            logic [31:0] c;
            int b;
            c = encode(32'($urandom_range(0, 15)), 4);
            b = $urandom_range(0, 7);
            c[b] = ~c[b];
            send4(c[7:0], ref_decode(c, 4));
        end
        drain();
`ifdef HAMMING_ERR_CNT_EN
        @(negedge clk);
        chk_int("cnt_single_saturated", int'(cs4), 3);
        chk_int("cnt_double_zero", int'(cd4), 0);
        @(posedge clk); #1;
`endif

        // random traffic with random backpressure
        rmode = 2;
        for (int i = 0; i < 60; i++) rand4(2);
        drain();
        rmode = 0;

        // DATA_W=11: clean codeword then every single-bit flip
        c11 = encode(32'h5A3, 11);
        send11(c11[15:0], mk(32'h5A3, 0, 1'b0, 1'b0));
        for (int f = 0; f < 16; f++) begin
            logic [15:0] cf;
            cf = c11[15:0];
            cf[f] = ~cf[f];
            send11(cf, mk(32'h5A3, f, 1'b1, 1'b0));
        end
        for (int i = 0; i < 10; i++) begin
            logic [31:0] c;
            int b0;
            int b1;
            c  = encode(32'($urandom_range(0, 2047)), 11);
            b0 = $urandom_range(0, 15);
            b1 = (b0 + $urandom_range(1, 15)) % 16;
            c[b0] = ~c[b0];
            if (i % 2 == 1) c[b1] = ~c[b1];
            send11(c[15:0], ref_decode(c, 11));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_hamming_secded_decoder

`default_nettype wire
